// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: fetch unit bundle carrying the pipeline controls, the imem request/response and the IF/ID buffer outputs.
interface if_fetch_unit_if;
  logic        stall_if;
  logic        flush_if;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  modport master (
    input  stall_if, flush_if, redirect_pc, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc, if_instr
  );
  modport slave (
    output stall_if, flush_if, redirect_pc, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC holder issuing one imem request at a time into a single-entry IF/ID buffer.
// Defining IF_FETCH_PERF_EN adds fetch_bubble_cnt_o, a saturating count of unstalled empty-buffer cycles.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic clk,
  input  logic reset,
`ifdef IF_FETCH_PERF_EN
  output logic [31:0] fetch_bubble_cnt_o,
`endif
  if_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, buf_pc_q, buf_pc_d, buf_instr_q, buf_instr_d;
  logic        buf_valid_q, buf_valid_d, load;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = bus.imem_req ? WAIT : FETCH;
      WAIT:    state_d = bus.imem_rvalid ? FETCH : bus.flush_if ? DISCARD : WAIT;
      DISCARD: state_d = bus.imem_rvalid ? FETCH : DISCARD;
      default: state_d = FETCH;
    endcase
  end
  // Issue only when the buffer is empty or drains this edge, so a response never finds it full.
  always_comb begin
    bus.imem_req  = (state_q == FETCH) && !bus.flush_if && (!buf_valid_q || !bus.stall_if);
    bus.imem_addr = pc_q;
  end
  assign load = (state_q == WAIT) && bus.imem_rvalid && !bus.flush_if;
  always_comb begin
    pc_d        = bus.flush_if ? bus.redirect_pc : load ? pc_q + 32'd4 : pc_q;
    buf_valid_d = load || (buf_valid_q && bus.stall_if && !bus.flush_if);
    buf_pc_d    = load ? pc_q : buf_valid_d ? buf_pc_q : 32'h0;
    buf_instr_d = load ? bus.imem_rdata : buf_valid_d ? buf_instr_q : NOP_INSTR;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= 32'h0;
      buf_instr_q <= NOP_INSTR;
    end else begin
      pc_q        <= pc_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end
  assign bus.if_valid = buf_valid_q;
  assign bus.if_pc    = buf_pc_q;
  assign bus.if_instr = buf_instr_q;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] bubble_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bubble_q <= 32'h0;
    else if (!buf_valid_q && !bus.stall_if && bubble_q != 32'hFFFF_FFFF) bubble_q <= bubble_q + 32'd1;
  end
  assign fetch_bubble_cnt_o = bubble_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed cycle tables for the fetch unit against a latency-programmable memory model.
module tb_if_fetch_unit;
  typedef struct packed {
    logic st; logic fl; logic [31:0] rd;
    logic rq; logic [31:0] ad; logic v; logic [31:0] pc; logic [31:0] ins;
  } vec_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] K   = 32'hC0DE_0000;
  logic clk = 1'b0, reset = 1'b1;
  int n_cmp = 0, n_err = 0, lat = 1, cnt = 0;
  logic [31:0] paddr, a1, a2;
  logic rq1, rq2;
  logic [97:0] obs, exp;
  if_fetch_unit_if b1();
  if_fetch_unit_if b2();
`ifdef IF_FETCH_PERF_EN
  logic [31:0] bub1, bub2;
  if_fetch_unit dut (.clk(clk), .reset(reset), .fetch_bubble_cnt_o(bub1), .bus(b1));
  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .reset(reset), .fetch_bubble_cnt_o(bub2), .bus(b2));
`else
  if_fetch_unit dut (.clk(clk), .reset(reset), .bus(b1));
  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .reset(reset), .bus(b2));
`endif
  always #5 clk = ~clk;
  function automatic vec_t mk(logic st, logic fl, logic [31:0] rd, logic rq, logic [31:0] ad,
                              logic v, logic [31:0] pc, logic [31:0] ins);
    return '{st, fl, rd, rq, ad, v, pc, ins};
  endfunction
  // Memory: main unit answers after lat cycles; the wrap instance always answers after 1 cycle.
  initial begin
    b1.imem_rvalid = 1'b0; b1.imem_rdata = 32'h0;
    b2.imem_rvalid = 1'b0; b2.imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      rq1 = b1.imem_req; a1 = b1.imem_addr;
      rq2 = b2.imem_req; a2 = b2.imem_addr;
      #1;
      b1.imem_rvalid = 1'b0;
      b2.imem_rvalid = rq2 && !reset;
      b2.imem_rdata  = a2 ^ K;
      if (reset) cnt = 0;
      else begin
        if (rq1) begin paddr = a1; cnt = lat; end
        if (cnt == 1) begin b1.imem_rvalid = 1'b1; b1.imem_rdata = paddr ^ K; end
        if (cnt > 0) cnt--;
      end
    end
  end
  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({b1.imem_req, b1.imem_addr, b1.if_valid, b1.if_pc, b1.if_instr} !== {1'b1, 32'h0, 1'b0, 32'h0, NOP}) begin
      n_err++;
      $display("FAIL reset_main got %h expected %h", {b1.imem_req, b1.imem_addr, b1.if_valid, b1.if_pc, b1.if_instr},
               {1'b1, 32'h0, 1'b0, 32'h0, NOP});
    end
    n_cmp++;
    if ({b2.imem_req, b2.imem_addr, b2.if_valid} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
      n_err++;
      $display("FAIL reset_wrap got %h expected %h", {b2.imem_req, b2.imem_addr, b2.if_valid}, {1'b1, 32'hFFFF_FFFC, 1'b0});
    end
    @(posedge clk); #2 reset = 1'b0;
  endtask
  task automatic test_sequential();
    vec_t v[6];
    v[0] = mk(0, 0, 0, 1, 32'h0, 0, 32'h0, NOP);
    v[1] = mk(0, 0, 0, 0, 32'h0, 0, 32'h0, NOP);
    v[2] = mk(0, 0, 0, 1, 32'h4, 1, 32'h0, 32'hC0DE_0000);
    v[3] = mk(0, 0, 0, 0, 32'h0, 0, 32'h0, NOP);
    v[4] = mk(0, 0, 0, 1, 32'h8, 1, 32'h4, 32'hC0DE_0004);
    v[5] = mk(0, 0, 0, 0, 32'h0, 0, 32'h0, NOP);
    foreach (v[i]) begin
      b1.stall_if = v[i].st; b1.flush_if = v[i].fl; b1.redirect_pc = v[i].rd;
      @(negedge clk);
      obs = {b1.imem_req, b1.imem_req ? b1.imem_addr : 32'h0, b1.if_valid, b1.if_pc, b1.if_instr};
      exp = {v[i].rq, v[i].ad, v[i].v, v[i].pc, v[i].ins};
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL seq[%0d] req/addr/valid/pc/instr got %h expected %h", i, obs, exp); end
      @(posedge clk); #2;
    end
  endtask
  task automatic test_stall();
    vec_t v[4];
    v[0] = mk(1, 0, 0, 0, 32'h0, 1, 32'h8, 32'hC0DE_0008);
    v[1] = mk(1, 0, 0, 0, 32'h0, 1, 32'h8, 32'hC0DE_0008);
    v[2] = mk(1, 0, 0, 0, 32'h0, 1, 32'h8, 32'hC0DE_0008);
    v[3] = mk(0, 0, 0, 1, 32'hC, 1, 32'h8, 32'hC0DE_0008);
    foreach (v[i]) begin
      b1.stall_if = v[i].st; b1.flush_if = v[i].fl; b1.redirect_pc = v[i].rd;
      @(negedge clk);
      obs = {b1.imem_req, b1.imem_req ? b1.imem_addr : 32'h0, b1.if_valid, b1.if_pc, b1.if_instr};
      exp = {v[i].rq, v[i].ad, v[i].v, v[i].pc, v[i].ins};
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL stall[%0d] req/addr/valid/pc/instr got %h expected %h", i, obs, exp); end
      @(posedge clk); #2;
    end
  endtask
  task automatic test_flush_wait();
    vec_t v[10];
    lat = 3;
    v[0] = mk(0, 0, 0,        0, 32'h0,   0, 32'h0,   NOP);
    v[1] = mk(0, 0, 0,        1, 32'h10,  1, 32'hC,   32'hC0DE_000C);
    v[2] = mk(0, 1, 32'h100,  0, 32'h0,   0, 32'h0,   NOP);
    v[3] = mk(0, 0, 0,        0, 32'h0,   0, 32'h0,   NOP);
    v[4] = mk(0, 0, 0,        0, 32'h0,   0, 32'h0,   NOP);
    v[5] = mk(0, 0, 0,        1, 32'h100, 0, 32'h0,   NOP);
    v[6] = mk(0, 0, 0,        0, 32'h0,   0, 32'h0,   NOP);
    v[7] = mk(0, 0, 0,        0, 32'h0,   0, 32'h0,   NOP);
    v[8] = mk(0, 0, 0,        0, 32'h0,   0, 32'h0,   NOP);
    v[9] = mk(0, 0, 0,        1, 32'h104, 1, 32'h100, 32'hC0DE_0100);
    foreach (v[i]) begin
      b1.stall_if = v[i].st; b1.flush_if = v[i].fl; b1.redirect_pc = v[i].rd;
      @(negedge clk);
      obs = {b1.imem_req, b1.imem_req ? b1.imem_addr : 32'h0, b1.if_valid, b1.if_pc, b1.if_instr};
      exp = {v[i].rq, v[i].ad, v[i].v, v[i].pc, v[i].ins};
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL flush_wait[%0d] req/addr/valid/pc/instr got %h expected %h", i, obs, exp); end
      @(posedge clk); #2;
    end
  endtask
  task automatic test_flush_stall();
    vec_t v[9];
    lat = 1;
    v[0] = mk(0, 1, 32'h10, 0, 32'h0,  0, 32'h0,  NOP);
    v[1] = mk(0, 0, 0,      0, 32'h0,  0, 32'h0,  NOP);
    v[2] = mk(0, 0, 0,      0, 32'h0,  0, 32'h0,  NOP);
    v[3] = mk(0, 0, 0,      1, 32'h10, 0, 32'h0,  NOP);
    v[4] = mk(0, 0, 0,      0, 32'h0,  0, 32'h0,  NOP);
    v[5] = mk(1, 1, 32'h40, 0, 32'h0,  1, 32'h10, 32'hC0DE_0010);
    v[6] = mk(0, 0, 0,      1, 32'h40, 0, 32'h0,  NOP);
    v[7] = mk(0, 0, 0,      0, 32'h0,  0, 32'h0,  NOP);
    v[8] = mk(0, 0, 0,      1, 32'h44, 1, 32'h40, 32'hC0DE_0040);
    foreach (v[i]) begin
      b1.stall_if = v[i].st; b1.flush_if = v[i].fl; b1.redirect_pc = v[i].rd;
      @(negedge clk);
      obs = {b1.imem_req, b1.imem_req ? b1.imem_addr : 32'h0, b1.if_valid, b1.if_pc, b1.if_instr};
      exp = {v[i].rq, v[i].ad, v[i].v, v[i].pc, v[i].ins};
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL flush_stall[%0d] req/addr/valid/pc/instr got %h expected %h", i, obs, exp); end
      @(posedge clk); #2;
    end
  endtask
  task automatic test_reset_mid_wait();
    vec_t v[3];
    lat = 3;
    v[0] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,  NOP);
    v[1] = mk(0, 0, 0, 1, 32'h48, 1, 32'h44, 32'hC0DE_0044);
    v[2] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,  NOP);
    foreach (v[i]) begin
      b1.stall_if = v[i].st; b1.flush_if = v[i].fl; b1.redirect_pc = v[i].rd;
      @(negedge clk);
      obs = {b1.imem_req, b1.imem_req ? b1.imem_addr : 32'h0, b1.if_valid, b1.if_pc, b1.if_instr};
      exp = {v[i].rq, v[i].ad, v[i].v, v[i].pc, v[i].ins};
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL mid_wait[%0d] req/addr/valid/pc/instr got %h expected %h", i, obs, exp); end
      @(posedge clk); #2;
    end
    reset = 1'b1;
    #1;
    obs = {b1.imem_req, b1.imem_addr, b1.if_valid, b1.if_pc, b1.if_instr};
    exp = {1'b1, 32'h0, 1'b0, 32'h0, NOP, 1'b0};
    n_cmp++;
    if (obs[96:0] !== exp[97:1]) begin n_err++; $display("FAIL async_reset got %h expected %h", obs[96:0], exp[97:1]); end
`ifdef IF_FETCH_PERF_EN
    n_cmp++;
    if (bub1 !== 32'h0) begin n_err++; $display("FAIL bubble_cnt_reset got %h expected 0", bub1); end
`endif
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({b1.imem_req, b1.imem_addr, b1.if_valid} !== {1'b1, 32'h0, 1'b0}) begin
      n_err++; $display("FAIL post_reset_req got %h expected %h", {b1.imem_req, b1.imem_addr, b1.if_valid}, {1'b1, 32'h0, 1'b0});
    end
    n_cmp++;
    if ({b2.imem_req, b2.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_err++; $display("FAIL post_reset_wrap_req got %h expected %h", {b2.imem_req, b2.imem_addr}, {1'b1, 32'hFFFF_FFFC});
    end
  endtask
  task automatic test_wrap();
    @(posedge clk); #2;
    @(negedge clk);
    n_cmp++;
    if ({b2.imem_req, b2.if_valid} !== 2'b00) begin
      n_err++; $display("FAIL wrap_wait got %b expected 00", {b2.imem_req, b2.if_valid});
    end
    @(posedge clk); #2;
    @(negedge clk);
    obs = {b2.imem_req, b2.imem_addr, b2.if_valid, b2.if_pc, b2.if_instr};
    exp = {1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h3F21_FFFC};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL wrap req/addr/valid/pc/instr got %h expected %h", obs, exp); end
  endtask
  initial begin
    b1.stall_if = 1'b0; b1.flush_if = 1'b0; b1.redirect_pc = 32'h0;
    b2.stall_if = 1'b0; b2.flush_if = 1'b0; b2.redirect_pc = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_flush_wait();
    test_flush_stall();
    test_reset_mid_wait();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch unit for the DHRUT-V core. It holds the program counter and issues one instruction-memory request at a time. Each returned word goes into a single-entry output buffer that feeds the IF/ID pipeline register. It sits directly upstream of IF/ID, follows that register's stall_if/flush_if controls, and accepts a redirect target from the branch/jump resolution logic.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value of if_instr whenever the buffer is empty or flushed (addi x0,x0,0).
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall_if  input  1  downstream cannot accept; buffer contents hold.
- flush_if  input  1  kill the buffer and any outstanding request, then redirect.
- redirect_pc  input  32  new fetch PC, sampled when flush_if=1.
- imem_req  output  1  request strobe, one cycle per request.
- imem_addr  output  32  request address; valid while imem_req=1.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  read data.
- if_valid  output  1  buffer holds a valid instruction.
- if_pc  output  32  PC of the buffered instruction.
- if_instr  output  32  buffered instruction.

## Operation
- State: pc_q, 1-entry buffer (buf_valid, buf_pc, buf_instr), and a FSM with states FETCH, WAIT, DISCARD.
- Consumption: the buffer drains at an edge where buf_valid=1 and stall_if=0.
- imem_req = (state==FETCH) && !flush_if && (!buf_valid || !stall_if). This is combinational. imem_addr = pc_q.
- FETCH: if imem_req=1, go to WAIT. Otherwise stay in FETCH.
- WAIT: on imem_rvalid=1, load the buffer (buf_pc=pc_q, buf_instr=imem_rdata, buf_valid=1), set pc_q += 4, and go to FETCH.
  - Because of the issue rule, the buffer is always empty when rvalid arrives.
- DISCARD: on imem_rvalid=1, drop the data and go to FETCH. pc_q is not changed.
- flush_if=1 takes priority over everything, including stall_if. At the edge:
  - pc_q <= redirect_pc and buf_valid <= 0.
  - If in WAIT without rvalid this cycle, go to DISCARD.
  - If in WAIT with rvalid this cycle, drop the data and go to FETCH.
  - If in DISCARD without rvalid, stay in DISCARD. With rvalid, go to FETCH.
  - If in FETCH, stay in FETCH. No request is issued in the flush cycle.
- imem_rvalid in FETCH is ignored.
- Arithmetic: PC increment is modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000. redirect_pc is taken verbatim; bits [1:0] are not masked.
- At most one request is outstanding. Memory latency is any value of 1 or more cycles.

## Timing
- Reset values:
  - state=FETCH, pc_q=RESET_PC.
  - if_valid=0, if_pc=32'h0, if_instr=NOP_INSTR.
  - imem_req=1 in the first cycle after reset deassertion; imem_addr=RESET_PC.
- Latency: with request in cycle t and rvalid in cycle t+L, if_valid rises at the edge ending cycle t+L. The next request is issued in cycle t+L+1.
  - Peak throughput is one instruction per 2 cycles at L=1.
- if_pc and if_instr are registered and hold while stalled. When buf_valid=0 they show 32'h0 and NOP_INSTR.
- After a flush edge, if_valid=0 for at least 1 cycle. The first request to redirect_pc comes in the cycle after the flush, or after the discarded rvalid.
- Reset mid-request: the FSM returns to FETCH immediately. The memory is reset by the same signal, so no stale rvalid arrives.

## Configuration
- IF_FETCH_PERF_EN defined: adds output fetch_bubble_cnt[31:0].
  - It increments each cycle that if_valid=0 and stall_if=0, and saturates at 32'hFFFF_FFFF.
  - It is reset to 0 and is not cleared by flush.
- IF_FETCH_PERF_EN undefined: the port and its counter do not exist; all other behaviour is identical.

## Test plan
- Reset, memory latency 1, stall_if=0 -> requests to 0x0, 0x4, 0x8, 0xC. if_pc shows the same sequence, one instruction every 2 cycles, each if_instr matching memory.
- stall_if=1 for 3 cycles while if_valid=1 at pc 0x8 -> if_pc/if_instr hold 0x8. No imem_req during the stall; the request to 0xC comes in the cycle stall_if falls.
- flush_if=1 with redirect_pc=0x100 during WAIT, latency 3 -> the returned word is dropped. The next request is to 0x100, and if_pc=0x100 follows.
- flush_if and stall_if both high with the buffer full at 0x10, redirect 0x40 -> if_valid=0 next cycle, then the request goes to 0x40.
- RESET_PC=32'hFFFF_FFFC -> the second request goes to 32'h0000_0000.
- Async reset asserted mid-WAIT -> outputs reach reset values immediately. After release, the request goes to RESET_PC; with IF_FETCH_PERF_EN, the counter is 0.
